// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: command encodings, FSM states
// and the default stack geometry.
package stack_pkg;

  localparam int STACK_DEPTH    = 64;
  localparam int STACK_PTR_BITS = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_POP2 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/stack_controller.sv
// Stack pointer owner and command sequencer for an external stack memory.
// Optional STACK_ERR_EN adds sticky err_overflow / err_underflow outputs.
module stack_controller
  import stack_pkg::*;
#(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = STACK_DEPTH,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [REG_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [REG_BITS-1:0] rsp_data1,
  output logic [REG_BITS-1:0] rsp_data2,
  output logic                mem_we,
  output logic [PTR_BITS-1:0] mem_addr,
  output logic [REG_BITS-1:0] mem_wdata,
  input  logic [REG_BITS-1:0] mem_rdata1,
  input  logic [REG_BITS-1:0] mem_rdata2,
  output logic [PTR_BITS:0]   sp,
  output logic                empty,
`ifdef STACK_ERR_EN
  output logic                err_overflow,
  output logic                err_underflow,
`endif
  output logic                full
);

  state_e                r_state;
  state_e                w_nextState;
  logic                  r_started;
  logic [PTR_BITS:0]     r_sp;
  logic                  r_isPop2;
  logic [REG_BITS-1:0]   r_wdata;
  logic [REG_BITS-1:0]   r_rspData1;
  logic [REG_BITS-1:0]   r_rspData2;

  op_e                   w_op;
  logic                  w_cmdReady;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pushOk;
  logic                  w_popOk;
  logic                  w_pop2Ok;
  logic                  w_readStart;
  logic [PTR_BITS-1:0]   w_topAddr;

  assign w_op        = op_e'(cmd_op);
  assign w_cmdReady  = r_started && (r_state == ST_IDLE);
  assign w_accept    = cmd_valid && w_cmdReady;
  assign w_full      = (r_sp == (PTR_BITS+1)'(DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_pushOk    = w_accept && (w_op == OP_PUSH) && !w_full;
  assign w_popOk     = w_accept && (w_op == OP_POP)  && !w_empty;
  assign w_pop2Ok    = w_accept && (w_op == OP_POP2) && (r_sp > (PTR_BITS+1)'(1));
  assign w_readStart = w_popOk || w_pop2Ok;
  assign w_topAddr   = PTR_BITS'(r_sp - (PTR_BITS+1)'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pushOk) begin
          w_nextState = ST_WRITE;
        end else if (w_readStart) begin
          w_nextState = ST_READ;
        end
      end
      ST_WRITE: w_nextState = ST_IDLE;
      ST_READ:  w_nextState = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
    endcase
  end

  // Pointer moves only when a memory access completes, so sp always reflects committed entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_started  <= 1'b0;
      r_sp       <= '0;
      r_isPop2   <= 1'b0;
      r_wdata    <= '0;
      r_rspData1 <= '0;
      r_rspData2 <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_pushOk) begin
        r_wdata <= cmd_data;
      end
      if (w_readStart) begin
        r_isPop2 <= w_pop2Ok;
      end
      if (r_state == ST_WRITE) begin
        r_sp <= r_sp + (PTR_BITS+1)'(1);
      end
      if (r_state == ST_READ) begin
        r_rspData1 <= mem_rdata1;
        r_rspData2 <= r_isPop2 ? mem_rdata2 : '0;
        r_sp       <= r_sp - (r_isPop2 ? (PTR_BITS+1)'(2) : (PTR_BITS+1)'(1));
      end
    end
  end

`ifdef STACK_ERR_EN
  logic r_errOverflow;
  logic r_errUnderflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_errOverflow  <= 1'b0;
      r_errUnderflow <= 1'b0;
    end else begin
      if (w_accept && (w_op == OP_PUSH) && w_full) begin
        r_errOverflow <= 1'b1;
      end
      if (w_accept && (((w_op == OP_POP) && w_empty) ||
                       ((w_op == OP_POP2) && (r_sp < (PTR_BITS+1)'(2))))) begin
        r_errUnderflow <= 1'b1;
      end
    end
  end

  assign err_overflow  = r_errOverflow;
  assign err_underflow = r_errUnderflow;
`endif

  // The read address is presented in the accept cycle so the registered memory returns data during READ.
  always_comb begin
    cmd_ready = w_cmdReady;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_sp[PTR_BITS-1:0];
    mem_wdata = r_wdata;
    unique case (r_state)
      ST_IDLE: begin
        if (w_readStart) begin
          mem_addr = w_topAddr;
        end
      end
      ST_WRITE: mem_we = 1'b1;
      ST_READ:  mem_addr = w_topAddr;
      ST_RESP:  rsp_valid = 1'b1;
    endcase
  end

  assign rsp_data1 = r_rspData1;
  assign rsp_data2 = r_rspData2;
  assign sp        = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: reset checks, a vector table,
// corner-case sequences and random commands against a queue-based stack model.
module tb_stack_controller;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data1;
  logic [31:0] rsp_data2;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata1;
  logic [31:0] mem_rdata2;
  logic [6:0]  sp;
  logic        empty;
  logic        full;
`ifdef STACK_ERR_EN
  logic        err_overflow;
  logic        err_underflow;
  bit          expOvf;
  bit          expUnf;
`endif

  int nVectors;
  int nMiscompares;

  logic [31:0] refStack[$];
  logic [31:0] mem [64];
  logic [5:0]  memAddr2;

  stack_controller dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1),
    .rsp_data2(rsp_data2),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata1(mem_rdata1),
    .mem_rdata2(mem_rdata2),
    .sp(sp),
    .empty(empty),
`ifdef STACK_ERR_EN
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
`endif
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack memory with registered reads, as the parent would instantiate it.
  assign memAddr2 = mem_addr - 6'd1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata1 <= mem[mem_addr];
    mem_rdata2 <= mem[memAddr2];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One complete command: handshake, then every cycle checked against the queue model.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data, input int holdCycles,
                               output logic [31:0] got1, output logic [31:0] got2);
    int n;
    int occ;
    bit legal;
    logic [31:0] e1;
    logic [31:0] e2;
    occ = refStack.size();
    got1 = 32'h0;
    got2 = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    legal = (op == 2'd1 && occ < 64) || (op == 2'd2 && occ >= 1) || (op == 2'd3 && occ >= 2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (legal && op == 2'd1) begin
      checkOutput("push_we", 64'(mem_we), 64'd1);
      checkOutput("push_addr", 64'(mem_addr), 64'(occ));
      checkOutput("push_wdata", 64'(mem_wdata), 64'(data));
      checkOutput("push_busy", 64'(cmd_ready), 64'd0);
      refStack.push_back(data);
      @(posedge clk);
      #1;
      checkOutput("push_sp", 64'(sp), 64'(refStack.size()));
      checkOutput("push_we_off", 64'(mem_we), 64'd0);
    end else if (legal) begin
      checkOutput("pop_addr", 64'(mem_addr), 64'(occ - 1));
      checkOutput("pop_rsp_early", 64'(rsp_valid), 64'd0);
      e1 = refStack.pop_back();
      e2 = 32'h0;
      if (op == 2'd3) e2 = refStack.pop_back();
      @(posedge clk);
      #1;
      checkOutput("pop_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("pop_data1", 64'(rsp_data1), 64'(e1));
      checkOutput("pop_data2", 64'(rsp_data2), 64'(e2));
      checkOutput("pop_sp", 64'(sp), 64'(refStack.size()));
      for (int h = 0; h < holdCycles; h++) begin
        @(posedge clk);
        #1;
        checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
        checkOutput("hold_data1", 64'(rsp_data1), 64'(e1));
        checkOutput("hold_data2", 64'(rsp_data2), 64'(e2));
        checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      got1 = rsp_data1;
      got2 = rsp_data2;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_release", 64'(rsp_valid), 64'd0);
      checkOutput("idle_ready", 64'(cmd_ready), 64'd1);
    end else begin
      checkOutput("nop_we", 64'(mem_we), 64'd0);
      checkOutput("nop_rsp", 64'(rsp_valid), 64'd0);
      checkOutput("nop_sp", 64'(sp), 64'(occ));
      checkOutput("nop_ready", 64'(cmd_ready), 64'd1);
`ifdef STACK_ERR_EN
      if (op == 2'd1) expOvf = 1'b1;
      if (op == 2'd2 || op == 2'd3) expUnf = 1'b1;
      checkOutput("err_overflow", 64'(err_overflow), 64'(expOvf));
      checkOutput("err_underflow", 64'(err_underflow), 64'(expUnf));
`endif
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          expSp;
    bit          chkRsp;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] g1;
    logic [31:0] g2;
    int r;
    nVectors     = 0;
    nMiscompares = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 32'h0;
    rsp_ready = 1'b0;
`ifdef STACK_ERR_EN
    expOvf = 1'b0;
    expUnf = 1'b0;
`endif

    vecs[0]  = '{2'd1, 32'hA5A5_0001, 1, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{2'd2, 32'h0,         0, 1'b1, 32'hA5A5_0001, 32'h0};
    vecs[2]  = '{2'd2, 32'h0,         0, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{2'd1, 32'h11,        1, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{2'd3, 32'h0,         1, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{2'd1, 32'h22,        2, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{2'd3, 32'h0,         0, 1'b1, 32'h22, 32'h11};
    vecs[7]  = '{2'd0, 32'hFFFF,      0, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{2'd1, 32'h33,        1, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{2'd1, 32'h44,        2, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{2'd2, 32'h0,         1, 1'b1, 32'h44, 32'h0};
    vecs[11] = '{2'd2, 32'h0,         0, 1'b1, 32'h33, 32'h0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sp", 64'(sp), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_rsp_data1", 64'(rsp_data1), 64'd0);
    checkOutput("rst_rsp_data2", 64'(rsp_data2), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("release_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("release_ready_high", 64'(cmd_ready), 64'd1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, 0, g1, g2);
      checkOutput("tbl_sp", 64'(sp), 64'(vecs[i].expSp));
      checkOutput("tbl_empty", 64'(empty), 64'(vecs[i].expSp == 0));
      if (vecs[i].chkRsp) begin
        checkOutput("tbl_data1", 64'(g1), 64'(vecs[i].exp1));
        checkOutput("tbl_data2", 64'(g2), 64'(vecs[i].exp2));
      end
    end

    // Fill to capacity, then overflow attempt
    for (int i = 0; i < 64; i++) applyStimulus(2'd1, $urandom, 0, g1, g2);
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_sp", 64'(sp), 64'd64);
    applyStimulus(2'd1, 32'hDEAD_BEEF, 0, g1, g2);
    checkOutput("overflow_sp", 64'(sp), 64'd64);
    checkOutput("overflow_full", 64'(full), 64'd1);

    // Backpressure on a POP from a full stack, then drain to one entry
    applyStimulus(2'd2, 32'h0, 5, g1, g2);
    checkOutput("after_full_pop", 64'(full), 64'd0);
    while (refStack.size() > 1) applyStimulus(2'd3, 32'h0, 0, g1, g2);
    applyStimulus(2'd3, 32'h0, 0, g1, g2);
    checkOutput("pop2_one_sp", 64'(sp), 64'd1);
    applyStimulus(2'd2, 32'h0, 1, g1, g2);
    applyStimulus(2'd2, 32'h0, 0, g1, g2);
    checkOutput("underflow_empty", 64'(empty), 64'd1);

    // Asynchronous reset while a response is pending
    applyStimulus(2'd1, 32'h7777_0001, 0, g1, g2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_rsp", 64'(rsp_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_sp", 64'(sp), 64'd0);
    checkOutput("async_empty", 64'(empty), 64'd1);
    checkOutput("async_data1", 64'(rsp_data1), 64'd0);
    refStack.delete();
`ifdef STACK_ERR_EN
    expOvf = 1'b0;
    expUnf = 1'b0;
    checkOutput("async_err_clear", 64'({err_overflow, err_underflow}), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rerelease_ready", 64'(cmd_ready), 64'd1);

    // Random commands against the queue model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      applyStimulus(2'd0, $urandom, 0, g1, g2);
      else if (r < 5)  applyStimulus(2'd1, $urandom, 0, g1, g2);
      else if (r < 8)  applyStimulus(2'd2, 32'h0, $urandom_range(0, 2), g1, g2);
      else             applyStimulus(2'd3, 32'h0, $urandom_range(0, 2), g1, g2);
      checkOutput("rnd_sp", 64'(sp), 64'(refStack.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
